// File: rtl/a2_pkg.sv
// Shared definitions for the 2-bit-slice to byte assembler.
// Contents: default slice/word widths, slots-per-word constant, FSM state
// type and a helper that sizes the slot counter.
package a2_pkg;

  localparam int unsigned CHUNK_W_DEF = 2;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned N_DEF       = DATA_W_DEF / CHUNK_W_DEF;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  // Slot counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/a2_byte_assembler_if.sv
// Slice-in / word-out handshake bundle for a2_byte_assembler.
// Signals: in_valid/in_bits/in_ready (slice side), out_valid/out_word/
// out_ready (word side); in_first/drop_pulse exist only when A2_RESYNC_EN
// is defined. master = upstream/downstream environment, slave = assembler.
interface a2_byte_assembler_if #(
  parameter int unsigned CHUNK_W = a2_pkg::CHUNK_W_DEF,
  parameter int unsigned DATA_W  = a2_pkg::DATA_W_DEF
);

  logic               in_valid;
  logic [CHUNK_W-1:0] in_bits;
  logic               in_ready;
  logic               out_valid;
  logic [DATA_W-1:0]  out_word;
  logic               out_ready;
`ifdef A2_RESYNC_EN
  logic               in_first;
  logic               drop_pulse;
`endif

`ifdef A2_RESYNC_EN
  modport master (
    output in_valid, in_bits, in_first, out_ready,
    input  in_ready, out_valid, out_word, drop_pulse
  );
  modport slave (
    input  in_valid, in_bits, in_first, out_ready,
    output in_ready, out_valid, out_word, drop_pulse
  );
`else
  modport master (
    output in_valid, in_bits, out_ready,
    input  in_ready, out_valid, out_word
  );
  modport slave (
    input  in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_word
  );
`endif

endinterface

// File: rtl/a2_slice_counter.sv
// Mod-N slot counter.
// Ports: clk, rst (sync, active-high), inc (count one slice), clear
// (restart at slot 0; with inc the current slice is taken as slot 0),
// cnt (current slot), wrap (combinational: this inc completes a word).
module a2_slice_counter import a2_pkg::*; #(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned CNT_W = cnt_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic [CNT_W-1:0] base_c;

  // Slot the current slice lands in, after an optional restart.
  always_comb begin
    base_c = clear ? '0 : cnt;
    wrap   = inc && (base_c == CNT_W'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : base_c + CNT_W'(1);
    end else begin
      cnt <= base_c;
    end
  end

endmodule

// File: rtl/a2_byte_assembler.sv
// Reassembles DATA_W-bit words from CHUNK_W-bit slices, MSB slice first.
// Ports: clk, rst (sync, active-high), bus (a2_byte_assembler_if.slave).
// in_ready is combinational from out_ready so a held word can be handed
// off in the same cycle the next word's first slice is taken.
// Option: A2_RESYNC_EN adds in_first (forces slot 0, discarding any
// partial word) and drop_pulse (one cycle after such a discard).
module a2_byte_assembler import a2_pkg::*; #(
  parameter int unsigned CHUNK_W = CHUNK_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  a2_byte_assembler_if.slave bus
);

  localparam int unsigned N_SLOTS = DATA_W / CHUNK_W;
  localparam int unsigned CNT_W   = cnt_width(N_SLOTS);

  localparam logic [0:0] S_COLLECT = COLLECT;
  localparam logic [0:0] S_FULL    = FULL;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              wrap;
  logic              accept;
  logic              resync;
  logic [CNT_W-1:0]  slot;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] sreg_nxt;
  logic [DATA_W-1:0] assembled;
  logic [DATA_W-1:0] word_nxt;
`ifdef A2_RESYNC_EN
  logic              drop_nxt;
`endif

  assign bus.in_ready = (state == S_COLLECT) || bus.out_ready;

  a2_slice_counter #(
    .N     (N_SLOTS),
    .CNT_W (CNT_W)
  ) u_slot_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .clear (resync),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  // Next state, slice insertion and output word selection.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    word_nxt  = bus.out_word;
    accept    = bus.in_valid && bus.in_ready;
    resync    = 1'b0;
`ifdef A2_RESYNC_EN
    resync    = accept && bus.in_first && (cnt != '0);
    drop_nxt  = resync;
`endif
    slot      = resync ? '0 : cnt;

    // Slot 0 starts from a clean word so stale partial bits never leak.
    assembled = (slot == '0) ? '0 : sreg;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (slot == CNT_W'(i)) begin
        assembled[DATA_W-1-i*CHUNK_W -: CHUNK_W] = bus.in_bits;
      end
    end

    case (state)
      S_COLLECT: state_nxt = S_COLLECT;
      S_FULL:    if (bus.out_ready) state_nxt = S_COLLECT;
      default:   state_nxt = S_COLLECT;
    endcase

    if (accept) begin
      if (wrap) begin
        state_nxt = S_FULL;
        word_nxt  = assembled;
        sreg_nxt  = '0;
      end else begin
        sreg_nxt  = assembled;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_COLLECT;
      sreg          <= '0;
      bus.out_word  <= '0;
      bus.out_valid <= 1'b0;
`ifdef A2_RESYNC_EN
      bus.drop_pulse <= 1'b0;
`endif
    end else begin
      state         <= state_nxt;
      sreg          <= sreg_nxt;
      bus.out_word  <= word_nxt;
      bus.out_valid <= (state_nxt == S_FULL);
`ifdef A2_RESYNC_EN
      bus.drop_pulse <= drop_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_a2_byte_assembler.sv
// Bench for a2_byte_assembler: directed vector table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_a2_byte_assembler;

  localparam int unsigned CW = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned NS = DW / CW;
`ifdef A2_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  a2_byte_assembler_if #(.CHUNK_W(CW), .DATA_W(DW)) bus ();

  a2_byte_assembler #(.CHUNK_W(CW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: accepted slices of the word in progress, plus held word.
  logic [CW-1:0] part[$];
  bit            m_held;
  logic [DW-1:0] m_word;
  bit            m_drop;

  typedef struct {
    bit            r;
    bit            v;
    logic [CW-1:0] b;
    bit            o;
    bit            rdy;
    bit            ov;
    logic [DW-1:0] w;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pack_part();
    logic [DW-1:0] w = '0;
    foreach (part[i]) w = (w << CW) | DW'(part[i]);
    return w;
  endfunction

  function automatic void model_reset();
    part.delete();
    m_held = 1'b0;
    m_word = '0;
    m_drop = 1'b0;
  endfunction

  // One clock: drive, check in_ready, advance model, check registered outputs.
  task automatic cycle(input bit r, input bit v, input logic [CW-1:0] b,
                       input bit o, input bit f, output bit got_rdy);
    bit exp_rdy;
    @(negedge clk);
    rst           = r;
    bus.in_valid  = v;
    bus.in_bits   = b;
    bus.out_ready = o;
`ifdef A2_RESYNC_EN
    bus.in_first  = f;
`endif
    #1;
    exp_rdy = !m_held || o;
    got_rdy = bus.in_ready;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      m_drop = 1'b0;
      if (m_held && o) m_held = 1'b0;
      if (v && exp_rdy) begin
        if (RESYNC && f && part.size() != 0) begin
          part.delete();
          m_drop = 1'b1;
        end
        part.push_back(b);
        if (part.size() == NS) begin
          m_word = pack_part();
          m_held = 1'b1;
          part.delete();
        end
      end
    end
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_held));
    if (m_held) chk("out_word", 32'(bus.out_word), 32'(m_word));
`ifdef A2_RESYNC_EN
    chk("drop_pulse", 32'(bus.drop_pulse), 32'(m_drop));
`endif
  endtask

  function automatic void add(input bit r, input bit v, input logic [CW-1:0] b,
                              input bit o, input bit rdy, input bit ov,
                              input logic [DW-1:0] w);
    vec_t t;
    t.r = r; t.v = v; t.b = b; t.o = o; t.rdy = rdy; t.ov = ov; t.w = w;
    tbl.push_back(t);
  endfunction

  initial begin
    bit rdy;
    int drops;
    logic [CW-1:0] sl;

    // Word 11_10_10_01 with out_ready=1: valid for exactly one cycle.
    add(0,1,2'b11,1, 1,0,8'h00); add(0,1,2'b10,1, 1,0,8'h00);
    add(0,1,2'b10,1, 1,0,8'h00); add(0,1,2'b01,1, 1,1,8'hE9);
    add(0,0,2'b00,1, 1,0,8'h00);
    // Same word held 5 cycles, then no-bubble handoff into word 00_01_10_11.
    add(0,1,2'b11,0, 1,0,8'h00); add(0,1,2'b10,0, 1,0,8'h00);
    add(0,1,2'b10,0, 1,0,8'h00); add(0,1,2'b01,0, 1,1,8'hE9);
    for (int i = 0; i < 5; i++) add(0,1,2'b00,0, 0,1,8'hE9);
    add(0,1,2'b00,1, 1,0,8'h00); add(0,1,2'b01,1, 1,0,8'h00);
    add(0,1,2'b10,1, 1,0,8'h00); add(0,1,2'b11,1, 1,1,8'h1B);
    add(0,0,2'b00,1, 1,0,8'h00);
    // Partial word killed by reset; only 0x0B emerges.
    add(0,1,2'b10,1, 1,0,8'h00); add(0,1,2'b11,1, 1,0,8'h00);
    add(1,0,2'b00,1, 1,0,8'h00);
    add(0,1,2'b00,1, 1,0,8'h00); add(0,1,2'b00,1, 1,0,8'h00);
    add(0,1,2'b10,1, 1,0,8'h00); add(0,1,2'b11,1, 1,1,8'h0B);
    add(0,0,2'b00,1, 1,0,8'h00);
    // Back-to-back 0xFF then 0x00 in eight cycles.
    for (int i = 0; i < 3; i++) add(0,1,2'b11,1, 1,0,8'h00);
    add(0,1,2'b11,1, 1,1,8'hFF);
    for (int i = 0; i < 3; i++) add(0,1,2'b00,1, 1,0,8'h00);
    add(0,1,2'b00,1, 1,1,8'h00);
    add(0,0,2'b00,1, 1,0,8'h00);

    // Reset.
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_bits = '0; bus.out_ready = 1'b0;
`ifdef A2_RESYNC_EN
    bus.in_first = 1'b0;
`endif
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_word", 32'(bus.out_word), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef A2_RESYNC_EN
    chk("rst_drop_pulse", 32'(bus.drop_pulse), 32'd0);
`endif

    // Directed table.
    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].o, 1'b0, rdy);
      chk("tbl_in_ready", 32'(rdy), 32'(tbl[i].rdy));
      chk("tbl_out_valid", 32'(bus.out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) chk("tbl_out_word", 32'(bus.out_word), 32'(tbl[i].w));
    end

`ifdef A2_RESYNC_EN
    // 01,01 then in_first with 11, then 00,00,00: one drop, then 0xC0.
    cycle(1, 0, 2'b00, 1, 0, rdy);
    drops = 0;
    cycle(0, 1, 2'b01, 1, 0, rdy); drops += int'(bus.drop_pulse);
    cycle(0, 1, 2'b01, 1, 0, rdy); drops += int'(bus.drop_pulse);
    cycle(0, 1, 2'b11, 1, 1, rdy); drops += int'(bus.drop_pulse);
    chk("resync_drop_now", 32'(bus.drop_pulse), 32'd1);
    cycle(0, 1, 2'b00, 1, 0, rdy); drops += int'(bus.drop_pulse);
    cycle(0, 1, 2'b00, 1, 0, rdy); drops += int'(bus.drop_pulse);
    cycle(0, 1, 2'b00, 1, 0, rdy); drops += int'(bus.drop_pulse);
    chk("resync_word_valid", 32'(bus.out_valid), 32'd1);
    chk("resync_word", 32'(bus.out_word), 32'hC0);
    chk("resync_drop_count", 32'(drops), 32'd1);
    cycle(0, 0, 2'b00, 1, 0, rdy);
`endif

    // Aligned in_first on every slot-0 slice: words as usual, never a drop.
    cycle(1, 0, 2'b00, 1, 0, rdy);
    drops = 0;
    for (int w = 0; w < 12; w++) begin
      for (int s = 0; s < int'(NS); s++) begin
        sl = CW'($urandom);
        cycle(0, 1, sl, 1, (s == 0), rdy);
`ifdef A2_RESYNC_EN
        drops += int'(bus.drop_pulse);
`endif
      end
    end
`ifdef A2_RESYNC_EN
    chk("aligned_first_drops", 32'(drops), 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(99) == 0), ($urandom_range(3) != 0), CW'($urandom),
            ($urandom_range(9) < 7), ($urandom_range(5) == 0), rdy);
    end
    cycle(0, 0, 2'b00, 1, 0, rdy);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
